// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - debounced button bank with queued press/release events and round-robin delivery
// Optional feature macro: BTN_AUTOREPEAT_EN (hold-to-repeat press events)
module btn_event_ctrl #(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 100000,
  parameter int DB_SAMPLES = 8,
  parameter int RPT_DELAY  = 500,
  parameter int RPT_RATE   = 100,
  localparam int ID_W      = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic [N_BTN-1:0] BTN_STATE,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [ID_W-1:0]  EVT_ID,
  output logic             EVT_PRESS,
  output logic             EVT_RPT,
  output logic             EVT_OVF,
  input  logic             CLR_OVF
);

  localparam int PW    = $clog2(TICK_DIV);
  localparam int CNT_W = $clog2(DB_SAMPLES);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state;
  logic [ID_W-1:0]    idx;
  logic [N_BTN-1:0]   sync1, sync2;
  logic [PW-1:0]      presc;
  logic               tick;
  logic [CNT_W-1:0]   cnt [N_BTN];
  logic [N_BTN-1:0]   pend, dir;
  logic [ID_W-1:0]    ptr;

  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_idx;
  logic               load, grant;
  logic               ev_set, ev_dir, ev_rpt, ev_busy, ev_write, ev_ovf;

  assign tick  = (presc == PW'(TICK_DIV - 1));
  assign load  = !EVT_VALID || EVT_READY;
  assign grant = load && gnt_vld;

  // Two-flop synchronizer for the raw asynchronous button inputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= BTN_IN;
      sync2 <= sync1;
    end
  end

  // Shared prescaler; tick is high for the last count before wrap
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  // Scan FSM: one button per clock after each tick, running its debounce counter
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      idx       <= '0;
      BTN_STATE <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            idx   <= '0;
          end
        end
        SCAN: begin
          if (sync2[idx] == BTN_STATE[idx]) begin
            cnt[idx] <= '0;
          end else if (cnt[idx] == CNT_W'(DB_SAMPLES - 1)) begin
            BTN_STATE[idx] <= ~BTN_STATE[idx];
            cnt[idx]       <= '0;
          end else begin
            cnt[idx] <= cnt[idx] + 1'b1;
          end
          if (idx == ID_W'(N_BTN - 1)) state <= IDLE;
          else idx <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  logic [HW-1:0]    hold [N_BTN];
  logic [N_BTN-1:0] rep_phase;
  logic [HW-1:0]    hold_nxt;
  logic             rpt_fire;
  logic [N_BTN-1:0] rpt;

  // First repeat after RPT_DELAY held ticks, then every RPT_RATE ticks
  always_comb begin
    hold_nxt = hold[idx] + 1'b1;
    rpt_fire = rep_phase[idx] ? (hold_nxt == HW'(RPT_RATE)) : (hold_nxt == HW'(RPT_DELAY));
  end

  // Hold counters advance once per tick on the scan visit, reset while released
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rep_phase <= '0;
      for (int i = 0; i < N_BTN; i++) hold[i] <= '0;
    end else if (state == SCAN) begin
      if (!BTN_STATE[idx]) begin
        hold[idx]      <= '0;
        rep_phase[idx] <= 1'b0;
      end else if (rpt_fire) begin
        hold[idx]      <= '0;
        rep_phase[idx] <= 1'b1;
      end else begin
        hold[idx] <= hold_nxt;
      end
    end
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{RPT_DELAY, RPT_RATE};
  assign EVT_RPT = 1'b0;
`endif

  // Event source for the button being scanned; an accepted level change beats a repeat
  always_comb begin
    ev_set = 1'b0;
    ev_dir = 1'b0;
    ev_rpt = 1'b0;
    if (state == SCAN) begin
      if (sync2[idx] != BTN_STATE[idx] && cnt[idx] == CNT_W'(DB_SAMPLES - 1)) begin
        ev_set = 1'b1;
        ev_dir = sync2[idx];
      end
`ifdef BTN_AUTOREPEAT_EN
      else if (BTN_STATE[idx] && rpt_fire) begin
        ev_set = 1'b1;
        ev_dir = 1'b1;
        ev_rpt = 1'b1;
      end
`endif
    end
  end

  // A pending slot is only "busy" if it is not being granted this same cycle
  always_comb begin
    ev_busy  = pend[idx] && !(grant && gnt_idx == idx);
    ev_write = ev_set && !(ev_rpt && ev_busy);
    ev_ovf   = ev_set && !ev_rpt && ev_busy;
  end

  // Round-robin search: lowest pending index at or after ptr, wrapping
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_BTN; k++) begin
      j = (int'(ptr) + k) % N_BTN;
      if (!gnt_vld && pend[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  // Output register, pending slots and sticky overflow flag
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      EVT_VALID <= 1'b0;
      EVT_ID    <= '0;
      EVT_PRESS <= 1'b0;
      EVT_OVF   <= 1'b0;
      ptr       <= '0;
      pend      <= '0;
      dir       <= '0;
`ifdef BTN_AUTOREPEAT_EN
      EVT_RPT   <= 1'b0;
      rpt       <= '0;
`endif
    end else begin
      if (load) begin
        EVT_VALID <= gnt_vld;
        if (gnt_vld) begin
          EVT_ID        <= gnt_idx;
          EVT_PRESS     <= dir[gnt_idx];
`ifdef BTN_AUTOREPEAT_EN
          EVT_RPT       <= rpt[gnt_idx];
`endif
          ptr           <= (gnt_idx == ID_W'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
          pend[gnt_idx] <= 1'b0;
        end
      end
      // Later assignment wins: a new event on the granted slot re-arms it
      if (ev_write) begin
        pend[idx] <= 1'b1;
        dir[idx]  <= ev_dir;
`ifdef BTN_AUTOREPEAT_EN
        rpt[idx]  <= ev_rpt;
`endif
      end
      if (ev_ovf) EVT_OVF <= 1'b1;
      else if (CLR_OVF) EVT_OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - directed self-checking bench for btn_event_ctrl
module tb_btn_event_ctrl;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic [3:0] BTN_IN;
  logic [3:0] BTN_STATE;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [1:0] EVT_ID;
  logic       EVT_PRESS;
  logic       EVT_RPT;
  logic       EVT_OVF;
  logic       CLR_OVF;

  int n_chk  = 0;
  int n_pass = 0;

  btn_event_ctrl #(
    .N_BTN(4), .TICK_DIV(8), .DB_SAMPLES(3), .RPT_DELAY(5), .RPT_RATE(2)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .BTN_IN(BTN_IN), .BTN_STATE(BTN_STATE),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_ID(EVT_ID),
    .EVT_PRESS(EVT_PRESS), .EVT_RPT(EVT_RPT), .EVT_OVF(EVT_OVF), .CLR_OVF(CLR_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [1:0] id, input logic p, input logic r);
    chk({tag, "_valid"}, 32'(EVT_VALID), 32'(v));
    if (v) begin
      chk({tag, "_id"}, 32'(EVT_ID), 32'(id));
      chk({tag, "_press"}, 32'(EVT_PRESS), 32'(p));
      chk({tag, "_rpt"}, 32'(EVT_RPT), 32'(r));
    end
  endtask

  initial begin
    RESETN    = 1'b0;
    BTN_IN    = 4'hF;
    EVT_READY = 1'b0;
    CLR_OVF   = 1'b0;
    cyc(3);
    chk("rst_state", 32'(BTN_STATE), 32'h0);
    chk("rst_valid", 32'(EVT_VALID), 32'h0);
    chk("rst_id", 32'(EVT_ID), 32'h0);
    chk("rst_press", 32'(EVT_PRESS), 32'h0);
    chk("rst_rpt", 32'(EVT_RPT), 32'h0);
    chk("rst_ovf", 32'(EVT_OVF), 32'h0);

`ifdef BTN_AUTOREPEAT_EN
    RESETN    = 1'b1;
    BTN_IN    = 4'b0001;
    EVT_READY = 1'b1;
    cyc(25);
    chk("ar_state", 32'(BTN_STATE), 32'h1);
    chk("ar_pre_valid", 32'(EVT_VALID), 32'h0);
    cyc(1);
    chk_evt("ar_press", 1'b1, 2'd0, 1'b1, 1'b0);
    cyc(1);
    chk("ar_idle", 32'(EVT_VALID), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc((k == 0) ? 38 : 15);
      chk("ar_gap", 32'(EVT_VALID), 32'h0);
      cyc(1);
      chk_evt("ar_rep", 1'b1, 2'd0, 1'b1, 1'b1);
    end
`else
    // Button 2 held: accepted on the third sampling tick, event one clock later
    RESETN = 1'b1;
    BTN_IN = 4'b0100;
    cyc(26);
    chk("db_early_state", 32'(BTN_STATE), 32'h0);
    cyc(1);
    chk("db_state", 32'(BTN_STATE), 32'h4);
    chk("db_nolatency_valid", 32'(EVT_VALID), 32'h0);
    cyc(1);
    chk_evt("b2_press", 1'b1, 2'd2, 1'b1, 1'b0);

    // Button 1 glitch shorter than the debounce window
    BTN_IN[1] = 1'b1;
    cyc(16);
    BTN_IN[1] = 1'b0;
    cyc(16);
    chk("glitch_state", 32'(BTN_STATE), 32'h4);
    chk_evt("b2_hold", 1'b1, 2'd2, 1'b1, 1'b0);

    // Button 1 press then release while the output is stalled: overflow
    BTN_IN[1] = 1'b1;
    cyc(22);
    chk("b1_press_state", 32'(BTN_STATE), 32'h6);
    chk("b1_press_ovf", 32'(EVT_OVF), 32'h0);
    BTN_IN[1] = 1'b0;
    cyc(23);
    chk("b1_pre_rel_state", 32'(BTN_STATE), 32'h6);
    chk("b1_pre_rel_ovf", 32'(EVT_OVF), 32'h0);
    cyc(1);
    chk("b1_rel_state", 32'(BTN_STATE), 32'h4);
    chk("ovf_set", 32'(EVT_OVF), 32'h1);
    chk_evt("b2_still", 1'b1, 2'd2, 1'b1, 1'b0);
    EVT_READY = 1'b1;
    cyc(1);
    chk_evt("b1_release", 1'b1, 2'd1, 1'b0, 1'b0);
    cyc(1);
    chk("drain_valid", 32'(EVT_VALID), 32'h0);
    chk("ovf_sticky", 32'(EVT_OVF), 32'h1);
    CLR_OVF = 1'b1;
    cyc(1);
    CLR_OVF = 1'b0;
    chk("ovf_clr", 32'(EVT_OVF), 32'h0);

    // Round robin: ptr=1 after granting button 0, then buttons 0 and 3 both pending
    EVT_READY = 1'b0;
    BTN_IN[0] = 1'b1;
    cyc(20);
    chk("b0_state", 32'(BTN_STATE), 32'h5);
    chk("b0_pre_valid", 32'(EVT_VALID), 32'h0);
    cyc(1);
    chk_evt("b0_press", 1'b1, 2'd0, 1'b1, 1'b0);
    BTN_IN = 4'b1100;
    cyc(26);
    chk("rr_state", 32'(BTN_STATE), 32'hC);
    chk("rr_ovf", 32'(EVT_OVF), 32'h0);
    chk_evt("rr_held", 1'b1, 2'd0, 1'b1, 1'b0);
    EVT_READY = 1'b1;
    cyc(1);
    chk_evt("rr_first", 1'b1, 2'd3, 1'b1, 1'b0);
    cyc(1);
    chk_evt("rr_second", 1'b1, 2'd0, 1'b0, 1'b0);
    cyc(1);
    chk("rr_empty", 32'(EVT_VALID), 32'h0);

    // Asynchronous reset in the middle of a scan
    cyc(2);
    BTN_IN = 4'hF;
    RESETN = 1'b0;
    #1;
    chk("mid_rst_state", 32'(BTN_STATE), 32'h0);
    chk("mid_rst_valid", 32'(EVT_VALID), 32'h0);
    chk("mid_rst_ovf", 32'(EVT_OVF), 32'h0);
    cyc(3);
    RESETN = 1'b1;
    cyc(24);
    chk("post_rst_state", 32'(BTN_STATE), 32'h0);
    chk("post_rst_valid", 32'(EVT_VALID), 32'h0);
    cyc(1);
    chk("all_s0", 32'(BTN_STATE), 32'h1);
    chk("all_v0", 32'(EVT_VALID), 32'h0);
    cyc(1);
    chk("all_s1", 32'(BTN_STATE), 32'h3);
    chk_evt("all_e0", 1'b1, 2'd0, 1'b1, 1'b0);
    cyc(1);
    chk("all_s2", 32'(BTN_STATE), 32'h7);
    chk_evt("all_e1", 1'b1, 2'd1, 1'b1, 1'b0);
    cyc(1);
    chk("all_s3", 32'(BTN_STATE), 32'hF);
    chk_evt("all_e2", 1'b1, 2'd2, 1'b1, 1'b0);
    cyc(1);
    chk_evt("all_e3", 1'b1, 2'd3, 1'b1, 1'b0);
    cyc(1);
    chk("all_empty", 32'(EVT_VALID), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
